output_argmax: RTL and testbench
================================

# output_argmax

Final classification stage of the network. It sits directly downstream of the 10-neuron output layer. It captures that layer's 80-bit packed logit vector when the layer's `done` rises, then scans the 10 signed 8-bit logits one per cycle. It reports the winning class index, the winning logit, the margin over the runner-up, and a low-confidence flag.

## Interface

Parameters:
- `N_CLASSES`, default 10: number of logits in the packed input.
- `DW`, default 8: logit width, signed two's complement.
- `MARGIN_THRESH`, default 4: a margin strictly below this value asserts `low_conf`.

Ports:
- `clk` in 1: single clock. All state updates on the posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `layer_done` in 1: `done` from the output layer. This is a sticky level.
- `logits` in N_CLASSES*DW: packed logits. Class i is at bits `[i*DW +: DW]`.
- `busy` out 1: high while capturing or scanning.
- `valid` out 1: the result outputs are meaningful.
- `class_idx` out 4: index of the maximum logit.
- `max_val` out DW: maximum logit, signed.
- `margin` out DW+1: max minus second-max, unsigned, range 0..255.
- `low_conf` out 1: `margin < MARGIN_THRESH`, qualified by `valid`.

## Operation

- **Edge detect:** `layer_done_q` is registered, with reset value 0. A start event is `layer_done && !layer_done_q`.
  - If `layer_done` is already high when reset deasserts, the first posedge counts as a start event.
- **State machine:** IDLE, SCAN, DONE.
- **IDLE or DONE, on a start event:**
  - Latch `logits` into the internal `lreg`.
  - Set `best = logit[0]`, `idx = 0`, `second = -128` (most negative DW value), `i = 1`.
  - Clear `valid`. Go to SCAN.
- **SCAN, each cycle:** take `x = lreg[i]`.
  - If `x > best`: `second <= best`, `best <= x`, `idx <= i`.
  - Else if `x > second`: `second <= x`.
  - Then `i <= i+1`.
  - After `i == N_CLASSES-1` is processed, go to DONE.
- **Comparisons** are signed, DW bits wide.
- **Margin** is computed as `best - second` after sign-extending both to DW+1 bits. The result is always ≥ 0.
- **Ties:**
  - Strict `>` on best, so the lowest index wins.
  - A value equal to best makes second equal to best, so margin = 0.
- **DONE:** `valid = 1`. The outputs hold until the next start event or reset.
- **Start events during SCAN are ignored.** The upstream `done` is sticky, so this path is unused in practice.
- **Input isolation:** `logits` is sampled only on the capture cycle. Later changes do not affect the result.
- **Reset mid-scan:** immediate return to IDLE, with all outputs and internal registers at 0.

## Timing

- Reset values:
  - `busy`, `valid`, `low_conf`: 0.
  - `class_idx`, `max_val`, `margin`: 0.
  - State: IDLE. `layer_done_q`: 0.
- The start event is seen at posedge T.
  - `busy` is high from T+1 through T+N_CLASSES-1 (SCAN, 9 cycles).
  - `valid` and all result outputs are registered and update together at posedge T+N_CLASSES (T+10 by default).
- Fixed latency: N_CLASSES cycles from start event to `valid`, independent of the data.
- Upstream updates on the negedge, so `layer_done` and `logits` are stable at every posedge. No extra synchroniser is needed.
- `low_conf` is registered with the other outputs and is 0 whenever `valid` is 0.

## Structure

- Shared package `nn_pkg`:
  - `DW` and `N_CLASSES` constants, shared with the hidden and output layers.
  - `argmax_state_t` enum {IDLE, SCAN, DONE}.
  - Helper function `logit_at(vec, i)` for packed-slice extraction.
- One sub-module, `argmax_update`. It is combinational: (x, best, second, idx, i) → (best', second', idx').
  - It is unit-testable in isolation.
- The top level holds the edge detector, the FSM, the index counter, `lreg`, and the output registers.

## Test plan

- **Distinct values:** logits {3,-5,20,7,0,1,-1,19,2,4}, `layer_done` rises → at T+10: `class_idx`=2, `max_val`=20, `margin`=1, `low_conf`=1.
- **All negative, tie:** all logits -128 except [6]=[8]=-3 → `class_idx`=6, `max_val`=-3, `margin`=0, `low_conf`=1 (lowest-index tie-break).
- **Extreme range:** [0]=127, rest -128 → `class_idx`=0, `margin`=255 (9-bit, no wrap), `low_conf`=0. Also [9]=127, rest -128 → `class_idx`=9.
- **Capture isolation:** change `logits` every cycle after the capture cycle → the result matches the vector present at T. `busy` is high exactly 9 cycles, and `valid` rises exactly at T+10.
- **Reset mid-scan:** pulse `rst_n` low at T+4 → all outputs 0 immediately. `layer_done` still high at release → a new start is detected on the first posedge after release, and a valid result follows 10 cycles later.
- **No retrigger:** hold `layer_done` high for 50 cycles → exactly one scan, and `valid` stays high with stable outputs.

Source files
------------

// File: rtl/nn_pkg.sv
// Constants and types shared by the hidden layer, output layer and argmax stage.
// logit_at pulls one signed logit out of a packed logit vector.
package nn_pkg;

   localparam int DW        = 8;
   localparam int N_CLASSES = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } argmax_state_t;

   function automatic logic signed [DW-1:0] logit_at(input logic [N_CLASSES*DW-1:0] vec,
                                                     input int                      i);
      return $signed(vec[i*DW +: DW]);
   endfunction

endpackage

// File: rtl/argmax_update.sv
// One step of the running argmax: folds logit x (at index i) into the
// current best/second/idx. Strict > on best keeps the lowest index on ties.
module argmax_update #(
   parameter int DW = 8,
   parameter int IW = 4
) (
   input  logic signed [DW-1:0] x,
   input  logic signed [DW-1:0] best,
   input  logic signed [DW-1:0] second,
   input  logic        [IW-1:0] idx,
   input  logic        [IW-1:0] i,
   output logic signed [DW-1:0] best_next,
   output logic signed [DW-1:0] second_next,
   output logic        [IW-1:0] idx_next
);

   always_comb begin
      best_next   = best;
      second_next = second;
      idx_next    = idx;
      if (x > best) begin
         second_next = best;
         best_next   = x;
         idx_next    = i;
      end else if (x > second) begin
         // x == best lands here, so a tie drives the margin to zero
         second_next = x;
      end
   end

endmodule

// File: rtl/output_argmax.sv
// Final classification stage: captures the packed logits on the rising edge of
// layer_done, scans one logit per cycle and registers class, max, margin, low_conf.
module output_argmax
   import nn_pkg::argmax_state_t, nn_pkg::IDLE, nn_pkg::SCAN, nn_pkg::DONE;
#(
   parameter int N_CLASSES     = nn_pkg::N_CLASSES,
   parameter int DW            = nn_pkg::DW,
   parameter int MARGIN_THRESH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    layer_done,
   input  logic [N_CLASSES*DW-1:0] logits,
   output logic                    busy,
   output logic                    valid,
   output logic [3:0]              class_idx,
   output logic signed [DW-1:0]    max_val,
   output logic [DW:0]             margin,
   output logic                    low_conf
);

   localparam logic [3:0]          LAST_IDX = 4'(N_CLASSES - 1);
   localparam logic [DW:0]         THRESH   = MARGIN_THRESH[DW:0];
   localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

   argmax_state_t          state_reg;
   logic                   layer_done_q;
   logic signed [DW-1:0]   lreg_reg [N_CLASSES];
   logic signed [DW-1:0]   cap      [N_CLASSES];
   logic signed [DW-1:0]   best_reg, second_reg;
   logic        [3:0]      idx_reg, i_reg;
   logic signed [DW-1:0]   x, best_next, second_next;
   logic        [3:0]      idx_next;
   logic        [DW:0]     margin_next;
   logic                   start;

   genvar gi;
   generate
      for (gi = 0; gi < N_CLASSES; gi++) begin : g_cap
         assign cap[gi] = $signed(logits[gi*DW +: DW]);
      end
   endgenerate

   assign start = layer_done && !layer_done_q;
   assign busy  = (state_reg == SCAN);
   assign x     = lreg_reg[i_reg];

   argmax_update #(
      .DW (DW),
      .IW (4)
   ) u_update (
      .x           (x),
      .best        (best_reg),
      .second      (second_reg),
      .idx         (idx_reg),
      .i           (i_reg),
      .best_next   (best_next),
      .second_next (second_next),
      .idx_next    (idx_next)
   );

   // One extra bit so 127 - (-128) = 255 cannot wrap
   assign margin_next = {best_next[DW-1], best_next} - {second_next[DW-1], second_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         layer_done_q <= 1'b0;
         best_reg     <= '0;
         second_reg   <= '0;
         idx_reg      <= '0;
         i_reg        <= '0;
         valid        <= 1'b0;
         class_idx    <= '0;
         max_val      <= '0;
         margin       <= '0;
         low_conf     <= 1'b0;
         for (int k = 0; k < N_CLASSES; k++) lreg_reg[k] <= '0;
      end else begin
         layer_done_q <= layer_done;
         unique case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  for (int k = 0; k < N_CLASSES; k++) lreg_reg[k] <= cap[k];
                  best_reg   <= cap[0];
                  second_reg <= MOST_NEG;
                  idx_reg    <= '0;
                  i_reg      <= 4'd1;
                  valid      <= 1'b0;
                  low_conf   <= 1'b0;
                  state_reg  <= SCAN;
               end
            end
            SCAN: begin
               best_reg   <= best_next;
               second_reg <= second_next;
               idx_reg    <= idx_next;
               i_reg      <= i_reg + 4'd1;
               // Final logit: publish the folded result on the same edge
               if (i_reg == LAST_IDX) begin
                  state_reg <= DONE;
                  valid     <= 1'b1;
                  class_idx <= idx_next;
                  max_val   <= best_next;
                  margin    <= margin_next;
                  low_conf  <= (margin_next < THRESH);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_output_argmax.sv
// Self-checking bench for output_argmax: per-scenario tasks, expected results
// queued at stimulus time and popped when valid rises.
module tb_output_argmax;
   import nn_pkg::*;

   typedef struct packed {
      logic [3:0]        idx;
      logic signed [7:0] mx;
      logic [8:0]        mg;
      logic              lc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        layer_done = 1'b0;
   logic [79:0] logits = '0;
   logic        busy, valid, low_conf;
   logic [3:0]  class_idx;
   logic signed [7:0] max_val;
   logic [8:0]  margin;

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   output_argmax dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .layer_done (layer_done),
      .logits     (logits),
      .busy       (busy),
      .valid      (valid),
      .class_idx  (class_idx),
      .max_val    (max_val),
      .margin     (margin),
      .low_conf   (low_conf)
   );

   always #5 clk = ~clk;

   // Reference: first index holding the maximum, runner-up = max over the other slots
   function automatic exp_t model(input logic [79:0] v);
      exp_t              e;
      int                id;
      logic signed [7:0] mx, sec, t;
      id = 0;
      mx = logit_at(v, 0);
      for (int i = 1; i < 10; i++) begin
         t = logit_at(v, i);
         if (t > mx) begin mx = t; id = i; end
      end
      sec = -8'sd128;
      for (int j = 0; j < 10; j++) begin
         t = logit_at(v, j);
         if (j != id && t > sec) sec = t;
      end
      e.idx = 4'(id);
      e.mx  = mx;
      e.mg  = 9'(int'(mx) - int'(sec));
      e.lc  = (int'(mx) - int'(sec)) < 4;
      return e;
   endfunction

   function automatic logic [79:0] pack(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
      logic [79:0] r;
      r = {8'(v9), 8'(v8), 8'(v7), 8'(v6), 8'(v5), 8'(v4), 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
      return r;
   endfunction

   task automatic start_scan(input logic [79:0] v);
      @(negedge clk);
      logits     = v;
      layer_done = 1'b1;
   endtask

   // lat = posedges from start event until valid is visible (10 expected)
   task automatic wait_result(input bit scramble, output int lat, output int busy_cnt);
      lat = -1;
      busy_cnt = 0;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(negedge clk);
         if (scramble) logits = {16'($urandom), 32'($urandom), 32'($urandom)};
         if (busy) busy_cnt++;
         if (valid) lat = k + 1;
      end
   endtask

   task automatic end_scan();
      @(negedge clk);
      layer_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      layer_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, valid, low_conf} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b required=000", {busy, valid, low_conf});
      end
      checks++;
      if ({class_idx, max_val, margin} !== 21'd0) begin
         failures++;
         $display("FAIL reset_results got=%h required=0", {class_idx, max_val, margin});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_busy got=%b required=0", busy);
      end
      $display("reset: busy=%b valid=%b", busy, valid);
   endtask

   // Runs one scan from a fixed vector and an expected value already queued
   task automatic test_fixed(input string name, input logic [79:0] v, input exp_t e);
      int   lat, bc;
      exp_t got;
      sb.push_back(e);
      start_scan(v);
      wait_result(1'b0, lat, bc);
      checks++;
      if (lat !== 10) begin
         failures++;
         $display("FAIL %s_latency got=%0d required=10", name, lat);
      end
      got = {class_idx, max_val, margin, low_conf};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL %s_result got idx=%0d max=%0d margin=%0d lc=%b required idx=%0d max=%0d margin=%0d lc=%b",
                  name, class_idx, max_val, margin, low_conf, e.idx, e.mx, e.mg, e.lc);
      end
      $display("%s: idx=%0d max=%0d margin=%0d low_conf=%b lat=%0d", name, class_idx, max_val, margin, low_conf, lat);
      end_scan();
   endtask

   task automatic test_isolation();
      int          lat, bc;
      logic [79:0] v;
      exp_t        e;
      v = pack(-7, 12, 12, 40, -40, 39, 0, 5, 6, 38);
      sb.push_back(exp_t'{4'd3, 8'sd40, 9'd1, 1'b1});
      start_scan(v);
      wait_result(1'b1, lat, bc);
      checks++;
      if (bc !== 9) begin
         failures++;
         $display("FAIL isolation_busy_cycles got=%0d required=9", bc);
      end
      checks++;
      if (lat !== 10) begin
         failures++;
         $display("FAIL isolation_latency got=%0d required=10", lat);
      end
      e = sb.pop_front();
      checks++;
      if ({class_idx, max_val, margin, low_conf} !== e) begin
         failures++;
         $display("FAIL isolation_result got idx=%0d max=%0d margin=%0d required idx=%0d max=%0d margin=%0d",
                  class_idx, max_val, margin, e.idx, e.mx, e.mg);
      end
      $display("isolation: idx=%0d max=%0d margin=%0d busy_cycles=%0d", class_idx, max_val, margin, bc);
      end_scan();
   endtask

   task automatic test_reset_midscan();
      int          lat, bc;
      logic [79:0] v;
      exp_t        e;
      v = pack(1, 2, 3, 4, 5, 6, 7, 8, 9, -9);
      start_scan(v);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, valid, low_conf, class_idx, max_val, margin} !== 24'd0) begin
         failures++;
         $display("FAIL midscan_reset_outputs got=%h required=0",
                  {busy, valid, low_conf, class_idx, max_val, margin});
      end
      @(negedge clk);
      sb.push_back(model(v));
      rst_n = 1'b1;
      wait_result(1'b0, lat, bc);
      checks++;
      if (lat !== 10 || bc !== 9) begin
         failures++;
         $display("FAIL midscan_restart_timing got lat=%0d busy=%0d required lat=10 busy=9", lat, bc);
      end
      e = sb.pop_front();
      checks++;
      if ({class_idx, max_val, margin, low_conf} !== e) begin
         failures++;
         $display("FAIL midscan_restart_result got idx=%0d max=%0d required idx=%0d max=%0d",
                  class_idx, max_val, e.idx, e.mx);
      end
      $display("reset_midscan: restart idx=%0d max=%0d lat=%0d", class_idx, max_val, lat);
      end_scan();
   endtask

   task automatic test_no_retrigger();
      int          lat, bc, extra_busy, unstable;
      logic [79:0] v;
      exp_t        e;
      v = pack(-1, -2, 9, 100, 3, 99, -100, 0, 0, 0);
      sb.push_back(exp_t'{4'd3, 8'sd100, 9'd1, 1'b1});
      start_scan(v);
      wait_result(1'b0, lat, bc);
      e = sb.pop_front();
      checks++;
      if ({class_idx, max_val, margin, low_conf} !== e) begin
         failures++;
         $display("FAIL retrigger_result got idx=%0d max=%0d required idx=%0d max=%0d",
                  class_idx, max_val, e.idx, e.mx);
      end
      extra_busy = 0;
      unstable = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         logits = {16'($urandom), 32'($urandom), 32'($urandom)};
         if (busy) extra_busy++;
         if ({valid, class_idx, max_val, margin, low_conf} !== {1'b1, e}) unstable++;
      end
      checks++;
      if (bc + extra_busy !== 9) begin
         failures++;
         $display("FAIL retrigger_busy_cycles got=%0d required=9", bc + extra_busy);
      end
      checks++;
      if (unstable !== 0) begin
         failures++;
         $display("FAIL retrigger_hold got=%0d changed cycles required=0", unstable);
      end
      $display("no_retrigger: busy_cycles=%0d unstable=%0d", bc + extra_busy, unstable);
      end_scan();
   endtask

   task automatic test_back_to_back();
      int          lat, bc;
      logic [79:0] v;
      exp_t        e;
      for (int n = 0; n < 20; n++) begin
         for (int c = 0; c < 10; c++)
            v[c*8 +: 8] = (n % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 7) - 4);
         sb.push_back(model(v));
         start_scan(v);
         wait_result(1'b0, lat, bc);
         e = sb.pop_front();
         checks++;
         if (lat !== 10 || {class_idx, max_val, margin, low_conf} !== e) begin
            failures++;
            $display("FAIL b2b_%0d got idx=%0d max=%0d margin=%0d lc=%b lat=%0d required idx=%0d max=%0d margin=%0d lc=%b lat=10",
                     n, class_idx, max_val, margin, low_conf, lat, e.idx, e.mx, e.mg, e.lc);
         end
         $display("b2b %0d: vec=%h idx=%0d max=%0d margin=%0d", n, v, class_idx, max_val, margin);
         end_scan();
      end
   endtask

   initial begin
      logic [79:0] v;
      test_reset();
      test_fixed("distinct", pack(3, -5, 20, 7, 0, 1, -1, 19, 2, 4),
                 exp_t'{4'd2, 8'sd20, 9'd1, 1'b1});
      v = {80{1'b0}};
      for (int c = 0; c < 10; c++) v[c*8 +: 8] = 8'h80;
      v[6*8 +: 8] = 8'hFD;
      v[8*8 +: 8] = 8'hFD;
      test_fixed("neg_tie", v, exp_t'{4'd6, -8'sd3, 9'd0, 1'b1});
      for (int c = 0; c < 10; c++) v[c*8 +: 8] = 8'h80;
      v[7:0] = 8'h7F;
      test_fixed("extreme_first", v, exp_t'{4'd0, 8'sd127, 9'd255, 1'b0});
      for (int c = 0; c < 10; c++) v[c*8 +: 8] = 8'h80;
      v[79:72] = 8'h7F;
      test_fixed("extreme_last", v, exp_t'{4'd9, 8'sd127, 9'd255, 1'b0});
      test_fixed("margin_at_thresh", pack(0, 10, 14, 0, 0, 0, 0, 0, 0, 0),
                 exp_t'{4'd2, 8'sd14, 9'd4, 1'b0});
      test_isolation();
      test_reset_midscan();
      test_no_retrigger();
      test_back_to_back();
      checks++;
      if (sb.size() !== 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
